// File: rtl/pipe_reg_hs.sv
// rtl/pipe_reg_hs.sv - handshaked pipeline stage register with 2-entry skid buffer and flush.
// Optional statistics counters enabled by defining PIPE_REG_STAT_EN.
module pipe_reg_hs #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4,
    parameter int TAG_W  = 5,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [TAG_W-1:0]  out_tag,
    output logic              fwd_valid,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic [TAG_W-1:0]  m_tag;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic [TAG_W-1:0]  s_tag;
    logic              accept;
    logic              deliver;

    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
    assign in_ready = ~s_valid;
    assign accept   = in_valid && in_ready;
    assign deliver  = m_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
            m_tag   <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!m_valid || deliver) begin
            if (s_valid) begin
                m_data  <= s_data;
                m_ctrl  <= s_ctrl;
                m_tag   <= s_tag;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else if (accept) begin
                m_data  <= in_data;
                m_ctrl  <= in_ctrl;
                m_tag   <= in_tag;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            s_data  <= in_data;
            s_ctrl  <= in_ctrl;
            s_tag   <= in_tag;
            s_valid <= 1'b1;
        end
    end

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_tag   = m_tag;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign fwd_valid = m_valid && out_ctrl[1];

`ifdef PIPE_REG_STAT_EN
    logic [STAT_W-1:0] stall_q;
    logic [STAT_W-1:0] flush_q;

    // Both counters saturate at all-ones; only rst clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (m_valid && !out_ready && stall_q != '1)
                stall_q <= stall_q + STAT_W'(1);
            if (flush && (m_valid || s_valid) && flush_q != '1)
                flush_q <= flush_q + STAT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_hs.sv
// tb/tb_pipe_reg_hs.sv - randomized self-checking bench for pipe_reg_hs against an occupancy-queue model.
module tb_pipe_reg_hs;

    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  c;
        logic [4:0]  t;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready, fwd_valid;
    logic [63:0]   in_data, out_data;
    logic [3:0]    in_ctrl, out_ctrl;
    logic [4:0]    in_tag, out_tag;
    logic [SW-1:0] stall_cnt, flush_cnt;

    int    total = 0;
    int    bad   = 0;
    beat_t q[$];
    logic [63:0] shown_d = '0;
    logic [4:0]  shown_t = '0;
    int    m_stall = 0;
    int    m_flush = 0;
    logic  acc_o;

    pipe_reg_hs #(.DATA_W(64), .CTRL_W(4), .TAG_W(5), .STAT_W(SW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .out_tag(out_tag), .fwd_valid(fwd_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic e_valid();
        return q.size() != 0;
    endfunction
    function automatic logic e_ready();
        return q.size() < 2;
    endfunction
    function automatic logic [63:0] e_data();
        return (q.size() != 0) ? q[0].d : shown_d;
    endfunction
    function automatic logic [4:0] e_tag();
        return (q.size() != 0) ? q[0].t : shown_t;
    endfunction
    function automatic logic [3:0] e_ctrl();
        return (q.size() != 0) ? q[0].c : 4'd0;
    endfunction
    function automatic logic e_fwd();
        return (q.size() != 0) && q[0].c[1];
    endfunction
    function automatic logic [SW-1:0] e_stall();
`ifdef PIPE_REG_STAT_EN
        return SW'(m_stall);
`else
        return '0;
`endif
    endfunction
    function automatic logic [SW-1:0] e_flush();
`ifdef PIPE_REG_STAT_EN
        return SW'(m_flush);
`else
        return '0;
`endif
    endfunction

    // One clock: drive inputs, advance the model as a bounded FIFO of depth 2, settle past the edge
    task automatic step(input logic iv, input logic [63:0] d, input logic [3:0] c, input logic [4:0] t,
                        input logic ordy, input logic fl, input logic r, output logic acc);
        logic dlv;
        beat_t b;
        in_valid = iv; in_data = d; in_ctrl = c; in_tag = t;
        out_ready = ordy; flush = fl; rst = r;
        b   = '{d: d, c: c, t: t};
        acc = iv && e_ready();
        dlv = e_valid() && ordy;
        @(posedge clk);
        if (r) begin
            q.delete(); shown_d = '0; shown_t = '0; m_stall = 0; m_flush = 0;
        end else begin
            if (q.size() != 0) begin
                shown_d = q[0].d; shown_t = q[0].t;
                if (!ordy && m_stall < SMAX) m_stall++;
            end
            if (fl) begin
                if (q.size() != 0 && m_flush < SMAX) m_flush++;
                q.delete();
            end else begin
                if (dlv) void'(q.pop_front());
                if (acc) q.push_back(b);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 0, 1, acc_o);
        step(0, 0, 0, 0, 0, 0, 1, acc_o);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        total++; if (out_ctrl !== 4'd0) begin bad++; $display("FAIL reset_ctrl got=%0h exp=0", out_ctrl); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
        total++; if (out_data !== 64'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", out_data); end
        total++; if (stall_cnt !== '0 || flush_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_streaming();
        int fwd_n = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1, 64'(i), 4'b0010, 5'd3, 1, 0, 0, acc_o);
            fwd_n += int'(fwd_valid);
            total++; if (out_valid !== 1'b1 || out_data !== 64'(i)) begin bad++; $display("FAIL stream_beat%0d got=%0b/%0h exp=1/%0h", i, out_valid, out_data, i); end
            total++; if (out_tag !== 5'd3 || in_ready !== 1'b1) begin bad++; $display("FAIL stream_tag%0d got=%0d/%0b exp=3/1", i, out_tag, in_ready); end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0, 0, acc_o);
            fwd_n += int'(fwd_valid);
        end
        total++; if (fwd_n != 8) begin bad++; $display("FAIL stream_fwd_cycles got=%0d exp=8", fwd_n); end
        total++; if (out_valid !== 1'b0 || out_data !== 64'd8) begin bad++; $display("FAIL stream_drain got=%0b/%0h exp=0/8", out_valid, out_data); end
    endtask

    task automatic test_back_pressure();
        logic [63:0] got[$];
        logic c_sent = 1'b0;
        step(1, 64'hA, 4'b0010, 5'd7, 1, 0, 0, acc_o);
        step(1, 64'hB, 4'b0010, 5'd7, 0, 0, 0, acc_o);
        total++; if (in_ready !== 1'b0 || out_data !== 64'hA) begin bad++; $display("FAIL bp_skid got=%0b/%0h exp=0/a", in_ready, out_data); end
        step(1, 64'hC, 4'b0010, 5'd7, 0, 0, 0, acc_o);
        total++; if (out_data !== 64'hA || out_valid !== 1'b1 || out_ctrl !== 4'b0010) begin bad++; $display("FAIL bp_hold got=%0h/%0b exp=a/1", out_data, out_valid); end
        total++; if (stall_cnt !== e_stall()) begin bad++; $display("FAIL bp_stall got=%0d exp=%0d", stall_cnt, e_stall()); end
        for (int cyc = 0; cyc < 10 && got.size() < 3; cyc++) begin
            if (out_valid) got.push_back(out_data);
            step(!c_sent, 64'hC, 4'b0010, 5'd7, 1, 0, 0, acc_o);
            if (acc_o) c_sent = 1'b1;
        end
        total++; if (got.size() != 3 || got[0] !== 64'hA || got[1] !== 64'hB || got[2] !== 64'hC) begin
            bad++; $display("FAIL bp_order got_n=%0d exp=3 (a,b,c)", got.size());
        end
    endtask

    task automatic test_flush_full();
        step(0, 0, 0, 0, 0, 0, 1, acc_o);
        step(1, 64'h1, 4'b0010, 5'd1, 0, 0, 0, acc_o);
        step(1, 64'h2, 4'b0010, 5'd2, 0, 0, 0, acc_o);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_prefill got=%0b exp=0", in_ready); end
        step(1, 64'hD, 4'b0010, 5'd4, 0, 1, 0, acc_o);
        total++; if (out_valid !== 1'b0 || out_ctrl !== 4'd0 || fwd_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_state got=%0b/%0h/%0b/%0b exp=0/0/0/1", out_valid, out_ctrl, fwd_valid, in_ready);
        end
        total++; if (flush_cnt !== e_flush()) begin bad++; $display("FAIL flush_cnt got=%0d exp=%0d", flush_cnt, e_flush()); end
`ifdef PIPE_REG_STAT_EN
        total++; if (flush_cnt !== SW'(1)) begin bad++; $display("FAIL flush_cnt_one got=%0d exp=1", flush_cnt); end
`endif
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0, 0, acc_o);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak got=%0b data=%0h exp=0", out_valid, out_data); end
        end
    endtask

    task automatic test_flush_empty();
        step(0, 0, 0, 0, 0, 0, 1, acc_o);
        step(0, 0, 0, 0, 1, 1, 0, acc_o);
        total++; if (flush_cnt !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_empty got=%0d/%0b/%0b exp=0/0/1", flush_cnt, out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_stall();
        for (int v = 0; v < 2; v++) begin
            step(1, 64'h11, 4'b0011, 5'd9, 0, 0, 0, acc_o);
            step(1, 64'h22, 4'b0011, 5'd9, 0, 0, 0, acc_o);
            step(0, 0, 0, 0, 1, 1, 0, acc_o);
            step(1, 64'h33, 4'b0011, 5'd9, 0, 0, 0, acc_o);
            step(1, 64'h44, 4'b0011, 5'd9, 0, 0, 0, acc_o);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_prefill%0d got=%0b exp=0", v, in_ready); end
            step(1, 64'h55, 4'b0011, 5'd9, 0, v[0], 1, acc_o);
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'd0 || out_tag !== 5'd0) begin
                bad++; $display("FAIL rst_state%0d got=%0b/%0b/%0h exp=0/1/0", v, out_valid, in_ready, out_data);
            end
            total++; if (stall_cnt !== '0 || flush_cnt !== '0) begin bad++; $display("FAIL rst_cnt%0d got=%0d/%0d exp=0/0", v, stall_cnt, flush_cnt); end
        end
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 0, 0, 0, 1, acc_o);
        step(1, 64'h5, 4'b0010, 5'd5, 0, 0, 0, acc_o);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, acc_o);
            total++; if (stall_cnt !== e_stall() || out_data !== 64'h5) begin bad++; $display("FAIL sat_cycle%0d got=%0d/%0h exp=%0d/5", i, stall_cnt, out_data, e_stall()); end
        end
`ifdef PIPE_REG_STAT_EN
        total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d exp=15", stall_cnt); end
`endif
    endtask

    task automatic test_random();
        step(0, 0, 0, 0, 0, 0, 1, acc_o);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, 4'($urandom), 5'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0, acc_o);
            total++; if (out_valid !== e_valid() || in_ready !== e_ready()) begin
                bad++; $display("FAIL rnd_hs%0d got=%0b/%0b exp=%0b/%0b", i, out_valid, in_ready, e_valid(), e_ready());
            end
            total++; if (out_data !== e_data() || out_tag !== e_tag() || out_ctrl !== e_ctrl() || fwd_valid !== e_fwd()) begin
                bad++; $display("FAIL rnd_beat%0d got=%0h/%0d/%0h/%0b exp=%0h/%0d/%0h/%0b", i, out_data, out_tag, out_ctrl, fwd_valid, e_data(), e_tag(), e_ctrl(), e_fwd());
            end
            total++; if (stall_cnt !== e_stall() || flush_cnt !== e_flush()) begin
                bad++; $display("FAIL rnd_cnt%0d got=%0d/%0d exp=%0d/%0d", i, stall_cnt, flush_cnt, e_stall(), e_flush());
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0; in_tag = '0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush_full();
        test_flush_empty();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
